// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU responder: command codes, status bit
// positions, word framing and the single-step fold helper.
package alu_pkg;

   // Frame: start, type, d[7:0], parity, stop (sent left to right)
   localparam int WORD_LEN    = 12;
   localparam int MAX_OPS_DEF = 9;

   typedef enum logic [7:0] {
      CMD_NOP = 8'h00,
      CMD_AND = 8'h01,
      CMD_OR  = 8'h02,
      CMD_XOR = 8'h03,
      CMD_ADD = 8'h04,
      CMD_SUB = 8'h05
   } cmd_e;

   localparam int ST_ERR      = 7;
   localparam int ST_ERR_DATA = 6;
   localparam int ST_ERR_CMD  = 5;
   localparam int ST_ERR_PAR  = 4;
   localparam int ST_CARRY    = 3;
   localparam int ST_OVF      = 2;
   localparam int ST_ZERO     = 1;
   localparam int ST_NEG      = 0;

   typedef struct packed {
      logic [15:0] res;
      logic        c;
      logic        v;
   } step_t;

   function automatic step_t alu_step(input logic [7:0] cmd, input logic [15:0] a,
                                      input logic [15:0] b);
      step_t       s;
      logic [16:0] t;
      s = '0;
      t = '0;
      case (cmd)
         CMD_AND: s.res = a & b;
         CMD_OR:  s.res = a | b;
         CMD_XOR: s.res = a ^ b;
         CMD_ADD: begin
            t     = {1'b0, a} + {1'b0, b};
            s.res = t[15:0];
            s.c   = t[16];
            s.v   = (a[15] == b[15]) && (t[15] != a[15]);
         end
         CMD_SUB: begin
            // t[16] is the borrow out of the unsigned subtraction
            t     = {1'b0, a} - {1'b0, b};
            s.res = t[15:0];
            s.c   = t[16];
            s.v   = (a[15] != b[15]) && (t[15] != a[15]);
         end
         default: s = '0;
      endcase
      return s;
   endfunction

   function automatic logic [WORD_LEN-1:0] make_word(input logic typ, input logic [7:0] d);
      return {1'b0, typ, d, ~(typ ^ (^d)), 1'b1};
   endfunction

endpackage

// File: rtl/serial_word_tx.sv
// Shifts one framed word out on o_sout, MSB first; line idles high.
// o_busy drops during the stop-bit cycle so the next word can follow back-to-back.
module serial_word_tx
   import alu_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                i_load,
   input  logic [WORD_LEN-1:0] i_word,
   output logic                o_busy,
   output logic                o_sout
);

   logic [WORD_LEN-1:0] r_shift;
   logic [3:0]          r_cnt;
   logic                r_sout;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift <= '1;
         r_cnt   <= '0;
         r_sout  <= 1'b1;
      end else if (i_load) begin
         r_sout  <= i_word[WORD_LEN-1];
         r_shift <= {i_word[WORD_LEN-2:0], 1'b1};
         r_cnt   <= 4'(WORD_LEN - 1);
      end else if (r_cnt != 4'd0) begin
         r_sout  <= r_shift[WORD_LEN-1];
         r_shift <= {r_shift[WORD_LEN-2:0], 1'b1};
         r_cnt   <= r_cnt - 4'd1;
      end else begin
         r_sout  <= 1'b1;
      end
   end

   assign o_busy = (r_cnt != 4'd0);
   assign o_sout = r_sout;

endmodule

// File: rtl/alu_serial_responder.sv
// Serial ALU: collects operand words, folds them on a command word, replies with
// status + 16-bit result. Define ALU_PARITY_CHK_EN to reject words with bad input parity.
module alu_serial_responder
   import alu_pkg::*;
#(
   parameter int MIN_OPS = 2,
   parameter int MAX_OPS = MAX_OPS_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic sin,
   output logic sout,
   output logic busy
);

   localparam int CW = $clog2(MAX_OPS + 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_RX     = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_TX     = 3'd4;

`ifdef ALU_PARITY_CHK_EN
   localparam bit PAR_CHK = 1'b1;
`else
   localparam bit PAR_CHK = 1'b0;
`endif

   logic [2:0]                r_state;
   logic [3:0]                r_bitcnt;
   logic [9:0]                r_rx;
   logic [MAX_OPS-1:0][15:0]  r_ops;
   logic [CW-1:0]             r_cnt;
   logic [CW-1:0]             r_idx;
   logic [7:0]                r_cmd;
   logic                      r_err_data;
   logic                      r_err_cmd;
   logic                      r_err_par;
   logic [15:0]               r_acc;
   logic                      r_carry;
   logic                      r_ovf;
   logic [1:0]                r_tx_idx;

   logic                      w_word_bad;
   logic                      w_dec_err_cmd;
   logic                      w_dec_err_data;
   logic                      w_err;
   logic [15:0]               w_result;
   logic [7:0]                w_status;
   step_t                     w_step;
   logic                      w_tx_load;
   logic                      w_tx_busy;
   logic [WORD_LEN-1:0]       w_tx_word;

   // r_rx = {type, d[7:0], parity} when the stop bit is on sin
   assign w_word_bad     = !sin || (PAR_CHK && !(^r_rx));
   assign w_dec_err_cmd  = (r_cmd > 8'h05);
   assign w_dec_err_data = r_err_data || (r_cnt < CW'(MIN_OPS));
   assign w_err          = r_err_data | r_err_cmd | r_err_par;
   assign w_result       = w_err ? 16'h0000 : r_acc;
   assign w_step         = alu_step(r_cmd, r_acc, r_ops[r_idx]);
   assign w_tx_load      = (r_state == S_TX) && !w_tx_busy && (r_tx_idx != 2'd3);
   assign busy           = (r_state == S_DECODE) || (r_state == S_EXEC) || (r_state == S_TX);

   always_comb begin
      w_status              = '0;
      w_status[ST_ERR]      = w_err;
      w_status[ST_ERR_DATA] = r_err_data;
      w_status[ST_ERR_CMD]  = r_err_cmd;
      w_status[ST_ERR_PAR]  = r_err_par;
      if (!w_err) begin
         w_status[ST_CARRY] = r_carry;
         w_status[ST_OVF]   = r_ovf;
         w_status[ST_ZERO]  = (r_acc == 16'h0000);
         w_status[ST_NEG]   = r_acc[15];
      end
   end

   always_comb begin
      case (r_tx_idx)
         2'd0:    w_tx_word = make_word(1'b1, w_status);
         2'd1:    w_tx_word = make_word(1'b0, w_result[15:8]);
         default: w_tx_word = make_word(1'b0, w_result[7:0]);
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_bitcnt   <= '0;
         r_rx       <= '0;
         r_ops      <= '0;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_cmd      <= '0;
         r_err_data <= 1'b0;
         r_err_cmd  <= 1'b0;
         r_err_par  <= 1'b0;
         r_acc      <= '0;
         r_carry    <= 1'b0;
         r_ovf      <= 1'b0;
         r_tx_idx   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!sin) begin
                  r_state  <= S_RX;
                  r_bitcnt <= '0;
               end
            end
            S_RX: begin
               if (r_bitcnt != 4'd10) begin
                  r_rx     <= {r_rx[8:0], sin};
                  r_bitcnt <= r_bitcnt + 4'd1;
               end else if (w_word_bad) begin
                  r_err_par <= 1'b1;
                  r_state   <= S_IDLE;
               end else if (r_rx[9]) begin
                  r_cmd   <= r_rx[8:1];
                  r_state <= S_DECODE;
               end else begin
                  if (r_cnt < CW'(MAX_OPS)) begin
                     r_ops[r_cnt] <= {8'h00, r_rx[8:1]};
                     r_cnt        <= r_cnt + 1'b1;
                  end else begin
                     r_err_data <= 1'b1;
                  end
                  r_state <= S_IDLE;
               end
            end
            S_DECODE: begin
               r_err_cmd  <= w_dec_err_cmd;
               r_err_data <= w_dec_err_data;
               r_acc      <= (r_cmd == CMD_NOP) ? 16'h0000 : r_ops[0];
               r_carry    <= 1'b0;
               r_ovf      <= 1'b0;
               r_idx      <= CW'(1);
               r_tx_idx   <= '0;
               // A single operand needs no fold step, so go straight to TX
               if (w_dec_err_cmd || w_dec_err_data || r_err_par || (r_cnt <= CW'(1)))
                  r_state <= S_TX;
               else
                  r_state <= S_EXEC;
            end
            S_EXEC: begin
               r_acc   <= w_step.res;
               r_carry <= r_carry | w_step.c;
               r_ovf   <= r_ovf | w_step.v;
               r_idx   <= r_idx + 1'b1;
               if (r_idx == r_cnt - 1'b1) r_state <= S_TX;
            end
            S_TX: begin
               if (w_tx_load) begin
                  r_tx_idx <= r_tx_idx + 2'd1;
               end else if ((r_tx_idx == 2'd3) && !w_tx_busy) begin
                  r_state    <= S_IDLE;
                  r_ops      <= '0;
                  r_cnt      <= '0;
                  r_err_data <= 1'b0;
                  r_err_cmd  <= 1'b0;
                  r_err_par  <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   serial_word_tx u_tx (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_tx_load),
      .i_word (w_tx_word),
      .o_busy (w_tx_busy),
      .o_sout (sout)
   );

endmodule

// File: tb/tb_alu_serial_responder.sv
// Directed bench for alu_serial_responder: operand/command sequences with
// hand-computed status, result and response latency.
module tb_alu_serial_responder;

   logic clk = 1'b0;
   logic rst;
   logic sin;
   logic sout;
   logic busy;

   int n_chk = 0;
   int n_err = 0;
   logic [7:0] ops[16];

   always #5 clk = ~clk;

   alu_serial_responder #(.MIN_OPS(2), .MAX_OPS(9)) dut (
      .clk  (clk),
      .rst  (rst),
      .sin  (sin),
      .sout (sout),
      .busy (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_word(input logic typ, input logic [7:0] d, input bit flip, input bit bad_stop);
      logic [11:0] w;
      w = {1'b0, typ, d, ~(typ ^ (^d)) ^ flip, ~bad_stop};
      for (int i = 11; i >= 0; i--) begin
         @(negedge clk);
         sin = w[i];
      end
      if (bad_stop) begin
         @(negedge clk);
         sin = 1'b1;
      end
   endtask

   // Latency counts edges after the one that samples the command stop bit
   task automatic recv_resp(input string tag, input bit jam, output int lat,
                            output logic [7:0] st, output logic [15:0] res);
      logic [11:0] w;
      logic [7:0]  d[3];
      bit          ok;
      lat = 0;
      st  = '0;
      res = '0;
      if (jam) begin
         @(posedge clk);
         #1 sin = 1'b0;
      end
      while (lat < 40) begin
         @(negedge clk);
         if (lat == 0) chk({tag, " busy_hi"}, 32'(busy), 32'd1);
         if (sout == 1'b0) break;
         lat++;
      end
      if (lat >= 40) begin
         chk({tag, " timeout"}, 32'd0, 32'd1);
         sin = 1'b1;
         return;
      end
      for (int n = 0; n < 3; n++) begin
         if (n > 0) @(negedge clk);
         w[11] = sout;
         for (int i = 10; i >= 0; i--) begin
            @(negedge clk);
            w[i] = sout;
         end
         ok = (w[11] == 1'b0) && (w[0] == 1'b1) && ((^w[10:1]) == 1'b1) && (w[10] == (n == 0));
         chk({tag, " frame"}, 32'(ok), 32'd1);
         d[n] = w[9:2];
      end
      sin = 1'b1;
      st  = d[0];
      res = {d[1], d[2]};
      @(negedge clk);
      chk({tag, " busy_lo"}, 32'(busy), 32'd0);
   endtask

   task automatic run_cmd(input string tag, input int nops, input logic [7:0] cmd,
                          input logic [7:0] exp_st, input logic [15:0] exp_res,
                          input int exp_lat, input bit jam);
      int          lat;
      logic [7:0]  st;
      logic [15:0] res;
      for (int i = 0; i < nops; i++) send_word(1'b0, ops[i], 1'b0, 1'b0);
      send_word(1'b1, cmd, 1'b0, 1'b0);
      recv_resp(tag, jam, lat, st, res);
      chk({tag, " lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, " status"}, 32'(st), 32'(exp_st));
      chk({tag, " result"}, 32'(res), 32'(exp_res));
   endtask

   initial begin
      int          lat;
      logic [7:0]  st;
      logic [15:0] res;
      rst = 1'b1;
      sin = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset sout", 32'(sout), 32'd1);
      chk("reset busy", 32'(busy), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      ops[0] = 8'h01; ops[1] = 8'hFF;
      run_cmd("add", 2, 8'h04, 8'h00, 16'h0100, 3, 1'b0);

      ops[0] = 8'h00; ops[1] = 8'h01;
      run_cmd("sub", 2, 8'h05, 8'h09, 16'hFFFF, 3, 1'b0);

      for (int i = 0; i < 10; i++) ops[i] = 8'hFF;
      run_cmd("and9", 9, 8'h01, 8'h00, 16'h00FF, 10, 1'b0);
      run_cmd("and10", 10, 8'h01, 8'hC0, 16'h0000, 2, 1'b0);

      ops[0] = 8'h05;
      run_cmd("single", 1, 8'h04, 8'hC0, 16'h0000, 2, 1'b0);

      ops[0] = 8'h11; ops[1] = 8'h22;
      run_cmd("badcmd", 2, 8'h07, 8'hA0, 16'h0000, 2, 1'b0);

      ops[0] = 8'h0F; ops[1] = 8'hF0; ops[2] = 8'h01;
      run_cmd("or", 3, 8'h02, 8'h00, 16'h00FF, 4, 1'b0);

      // sin held low through the whole response must be ignored
      ops[0] = 8'hFF; ops[1] = 8'h0F;
      run_cmd("xor_jam", 2, 8'h03, 8'h00, 16'h00F0, 3, 1'b1);

      ops[0] = 8'h12; ops[1] = 8'h34;
      run_cmd("nop", 2, 8'h00, 8'h02, 16'h0000, 3, 1'b0);

      // flipped input parity on the third operand
      send_word(1'b0, 8'h10, 1'b0, 1'b0);
      send_word(1'b0, 8'h20, 1'b0, 1'b0);
      send_word(1'b0, 8'h30, 1'b1, 1'b0);
      send_word(1'b1, 8'h04, 1'b0, 1'b0);
      recv_resp("parity", 1'b0, lat, st, res);
`ifdef ALU_PARITY_CHK_EN
      chk("parity lat", 32'(lat), 32'd2);
      chk("parity status", 32'(st), 32'h90);
      chk("parity result", 32'(res), 32'h0000);
`else
      chk("parity lat", 32'(lat), 32'd4);
      chk("parity status", 32'(st), 32'h00);
      chk("parity result", 32'(res), 32'h0060);
`endif

      // bad stop bit on a middle operand is rejected in every build
      send_word(1'b0, 8'h01, 1'b0, 1'b0);
      send_word(1'b0, 8'h02, 1'b0, 1'b1);
      send_word(1'b0, 8'h03, 1'b0, 1'b0);
      send_word(1'b1, 8'h04, 1'b0, 1'b0);
      recv_resp("stopbit", 1'b0, lat, st, res);
      chk("stopbit lat", 32'(lat), 32'd2);
      chk("stopbit status", 32'(st), 32'h90);
      chk("stopbit result", 32'(res), 32'h0000);

      // reset in the middle of a response
      send_word(1'b0, 8'h01, 1'b0, 1'b0);
      send_word(1'b0, 8'h02, 1'b0, 1'b0);
      send_word(1'b1, 8'h04, 1'b0, 1'b0);
      repeat (8) @(negedge clk);
      chk("midrst busy_pre", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst sout", 32'(sout), 32'd1);
      chk("midrst busy", 32'(busy), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrst sout_idle", 32'(sout), 32'd1);

      ops[0] = 8'h02; ops[1] = 8'h03;
      run_cmd("post_rst", 2, 8'h04, 8'h00, 16'h0005, 3, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected completion");
      $fatal(1);
   end

endmodule
